// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core.
//   - pcsrc encodings driven by the controller into the fetch stage
//   - NOP encoding used to fill flushed pipeline slots
//   - primary opcode constants shared between decode and controller
package mips_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_JMP = 2'b01;
   localparam logic [1:0] PCSRC_JAL = 2'b10;
   localparam logic [1:0] PCSRC_BR  = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/mips_fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             flush the slot (NOP, pc4 = 0, invalid); beats hold
//   hold              keep current contents (load-use stall)
//   fetch_instr/pc4   instruction and PC+4 coming out of fetch
//   instr/pc4/valid   registered values presented to decode
module if_id_reg
   import mips_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               hold,
   input  logic [INSTR_W-1:0] fetch_instr,
   input  logic [PC_W-1:0]    fetch_pc4,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc4,
   output logic               valid
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         instr <= INSTR_W'(NOP_INSTR);
         pc4   <= '0;
         valid <= 1'b0;
      end else if (!hold) begin
         instr <= fetch_instr;
         pc4   <= fetch_pc4;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage of the pipelined MIPS core.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   imem_addr / imem_rdata     combinational instruction memory interface
//   stall                      load-use hold from the hazard unit
//   pcsrc                      next-PC select resolved in EX (seq/jmp/jal/br)
//   jump_target, branch_target redirect targets
//   ifid_instr/pc4/valid       IF/ID register outputs to decode
//   flush_idex                 combinational request to clear ID/EX
//   fetch_cnt, flush_cnt       saturating performance counters
module mips_fetch_stage
   import mips_pkg::*;
#(
   parameter int                PC_W     = 32,
   parameter int                INSTR_W  = 32,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic [1:0]         pcsrc,
   input  logic [PC_W-1:0]    jump_target,
   input  logic [PC_W-1:0]    branch_target,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc4,
   output logic               ifid_valid,
   output logic               flush_idex,
   output logic [CNT_W-1:0]   fetch_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc4;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_next;
   logic            redirect;
   logic            load;

   assign imem_addr  = pc;
   assign pc4        = pc + PC_W'(4);
   assign redirect   = (pcsrc != PCSRC_SEQ);
   assign flush_idex = redirect;
   // a redirect overrides a stall: the stalled instruction is wrong-path
   assign load       = !redirect && !stall;

   always_comb begin
      target  = (pcsrc == PCSRC_BR) ? branch_target : jump_target;
      pc_next = pc4;
      if (redirect) begin
         pc_next = {target[PC_W-1:2], 2'b00};
      end else if (stall) begin
         pc_next = pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (load && (fetch_cnt != '1)) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
         end
         if (redirect && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   if_id_reg #(
      .INSTR_W (INSTR_W),
      .PC_W    (PC_W)
   ) u_if_id (
      .clk         (clk),
      .rst         (rst),
      .clear       (redirect),
      .hold        (stall),
      .fetch_instr (imem_rdata),
      .fetch_pc4   (pc4),
      .instr       (ifid_instr),
      .pc4         (ifid_pc4),
      .valid       (ifid_valid)
   );

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage (counters narrowed to 4 bits so
// saturation is reachable quickly).
module tb_mips_fetch_stage;

   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       imem_addr;
   logic [31:0]       imem_rdata;
   logic              stall;
   logic [1:0]        pcsrc;
   logic [31:0]       jump_target;
   logic [31:0]       branch_target;
   logic [31:0]       ifid_instr;
   logic [31:0]       ifid_pc4;
   logic              ifid_valid;
   logic              flush_idex;
   logic [CNT_W-1:0]  fetch_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   int          m_fc;
   int          m_flc;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   assign imem_rdata = 32'h100 + imem_addr;

   mips_fetch_stage #(
      .PC_W     (32),
      .INSTR_W  (32),
      .RESET_PC (32'h0),
      .CNT_W    (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .pcsrc         (pcsrc),
      .jump_target   (jump_target),
      .branch_target (branch_target),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_valid    (ifid_valid),
      .flush_idex    (flush_idex),
      .fetch_cnt     (fetch_cnt),
      .flush_cnt     (flush_cnt)
   );

   always @(posedge clk) begin
      if (rst === 1'b0) begin
         assert (!$isunknown(pcsrc)) else $error("pcsrc is X/Z while out of reset");
      end
   end

   // Drives one cycle of stimulus, updates the model, pushes expected IF/ID
   // contents on a fetch and pops/compares them once the DUT has loaded.
   task automatic cycle(input logic s, input logic [1:0] ps,
                        input logic [31:0] jt, input logic [31:0] bt,
                        input logic r);
      logic [31:0] tgt;
      logic [63:0] exp_e;
      int kind; // 0 reset, 1 flush, 2 hold, 3 load
      stall = s; pcsrc = ps; jump_target = jt; branch_target = bt; rst = r;
      #1;
      n_checks++;
      if (flush_idex !== (ps != 2'b00)) begin
         n_fail++;
         $display("FAIL flush_idex: got %b expected %b", flush_idex, (ps != 2'b00));
      end
      if (!r) begin
         n_checks++;
         if (imem_addr !== m_pc) begin
            n_fail++;
            $display("FAIL imem_addr_pre: got %h expected %h", imem_addr, m_pc);
         end
      end
      if (r) begin
         kind = 0;
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_fc = 0; m_flc = 0;
         sb_q.delete();
      end else if (ps != 2'b00) begin
         kind = 1;
         tgt = (ps == 2'b11) ? bt : jt;
         m_pc = {tgt[31:2], 2'b00};
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         if (m_flc < CNT_MAX) m_flc++;
      end else if (s) begin
         kind = 2;
      end else begin
         kind = 3;
         sb_q.push_back({32'h100 + m_pc, m_pc + 32'd4});
         m_pc = m_pc + 32'd4;
         if (m_fc < CNT_MAX) m_fc++;
      end
      @(posedge clk);
      #1;
      if (kind == 3) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got size 0 expected >0");
         end else begin
            exp_e = sb_q.pop_front();
            m_instr = exp_e[63:32];
            m_pc4 = exp_e[31:0];
            m_valid = 1'b1;
         end
      end
      n_checks++;
      if (ifid_instr !== m_instr) begin
         n_fail++;
         $display("FAIL ifid_instr: got %h expected %h", ifid_instr, m_instr);
      end
      n_checks++;
      if (ifid_pc4 !== m_pc4) begin
         n_fail++;
         $display("FAIL ifid_pc4: got %h expected %h", ifid_pc4, m_pc4);
      end
      n_checks++;
      if (ifid_valid !== m_valid) begin
         n_fail++;
         $display("FAIL ifid_valid: got %b expected %b", ifid_valid, m_valid);
      end
      n_checks++;
      if (imem_addr !== m_pc) begin
         n_fail++;
         $display("FAIL pc: got %h expected %h", imem_addr, m_pc);
      end
      n_checks++;
      if (fetch_cnt !== CNT_W'(m_fc)) begin
         n_fail++;
         $display("FAIL fetch_cnt: got %0d expected %0d", fetch_cnt, m_fc);
      end
      n_checks++;
      if (flush_cnt !== CNT_W'(m_flc)) begin
         n_fail++;
         $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, m_flc);
      end
   endtask

   task automatic test_reset();
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      n_checks++;
      if ({imem_addr, ifid_instr, ifid_pc4, ifid_valid} !== 97'h0) begin
         n_fail++;
         $display("FAIL reset_state: got pc=%h instr=%h pc4=%h v=%b expected all zero",
                  imem_addr, ifid_instr, ifid_pc4, ifid_valid);
      end
   endtask

   task automatic test_sequential();
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (fetch_cnt !== CNT_W'(5) || ifid_instr !== 32'h110 || ifid_pc4 !== 32'h14) begin
         n_fail++;
         $display("FAIL seq_five: got cnt=%0d instr=%h pc4=%h expected 5 00000110 00000014",
                  fetch_cnt, ifid_instr, ifid_pc4);
      end
   endtask

   task automatic test_stall();
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      cycle(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
      cycle(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (imem_addr !== 32'h10 || ifid_pc4 !== 32'h10) begin
         n_fail++;
         $display("FAIL stall_hold: got pc=%h pc4=%h expected 00000010 00000010",
                  imem_addr, ifid_pc4);
      end
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_branch();
      // continues from pc = 0x18
      cycle(1'b0, 2'b11, 32'h0, 32'h40, 1'b0);
      n_checks++;
      if (imem_addr !== 32'h40 || ifid_valid !== 1'b0 || flush_cnt !== CNT_W'(1)) begin
         n_fail++;
         $display("FAIL branch_redirect: got pc=%h v=%b flush_cnt=%0d expected 00000040 0 1",
                  imem_addr, ifid_valid, flush_cnt);
      end
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (ifid_instr !== 32'h140) begin
         n_fail++;
         $display("FAIL branch_first: got %h expected 00000140", ifid_instr);
      end
   endtask

   task automatic test_stall_jal();
      cycle(1'b1, 2'b10, 32'h203, 32'h0, 1'b0);
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      cycle(1'b1, 2'b01, 32'h80, 32'h0, 1'b0);
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_wrap_reset();
      cycle(1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0);
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (imem_addr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'hFC) begin
         n_fail++;
         $display("FAIL wrap: got pc=%h pc4=%h instr=%h expected 0 0 000000fc",
                  imem_addr, ifid_pc4, ifid_instr);
      end
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      cycle(1'b0, 2'b01, 32'h300, 32'h0, 1'b1);
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_saturation();
      cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (fetch_cnt !== CNT_W'(CNT_MAX)) begin
         n_fail++;
         $display("FAIL fetch_sat: got %0d expected %0d", fetch_cnt, CNT_MAX);
      end
      for (int i = 0; i < 18; i++) begin
         cycle(i[0], (i % 3 == 0) ? 2'b11 : 2'b01, 32'h1000 + i * 8, 32'h2000 + i * 4, 1'b0);
      end
      n_checks++;
      if (flush_cnt !== CNT_W'(CNT_MAX)) begin
         n_fail++;
         $display("FAIL flush_sat: got %0d expected %0d", flush_cnt, CNT_MAX);
      end
      for (int i = 0; i < 12; i++) begin
         cycle(($urandom_range(0, 3) == 0), 2'b00, 32'h0, 32'h0, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; pcsrc = 2'b00;
      jump_target = 32'h0; branch_target = 32'h0;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_fc = 0; m_flc = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_stall_jal();
      test_wrap_reset();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
